// File: rtl/fizzbuzz_gen_pkg.sv
// Shared types and ASCII constants for the FizzBuzz byte source.
package fizzbuzz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        LT_NUM      = 2'd0,
        LT_FIZZ     = 2'd1,
        LT_BUZZ     = 2'd2,
        LT_FIZZBUZZ = 2'd3
    } line_t;

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_ZERO = 8'h30;

    localparam logic [7:0] FIZZ [4] = '{8'h46, 8'h69, 8'h7A, 8'h7A};
    localparam logic [7:0] BUZZ [4] = '{8'h42, 8'h75, 8'h7A, 8'h7A};

endpackage

// File: rtl/fizzbuzz_gen_if.sv
// Byte-offer channel between the FizzBuzz source and the UART transmitter.
interface fizzbuzz_gen_if;
    // Handshake: tx_valid is a one-cycle pulse carrying tx_data, which then
    // stays stable. The sink raises tx_busy while it serialises the byte; the
    // source ignores tx_busy for one guard cycle after the pulse, then offers
    // the next byte only after seeing tx_busy low, so one byte is in flight.
    logic       start;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        input  tx_busy,
        output tx_data,
        output tx_valid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output tx_busy,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fizzbuzz_gen_bcd_counter.sv
// Packed BCD counter that starts at 1 and reports its significant-digit count.
module bcd_counter #(
    parameter int N_DIG = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    output logic [4*N_DIG-1:0]         digits,
    output logic [$clog2(N_DIG+1)-1:0] ndig
);
    localparam int NDW = $clog2(N_DIG + 1);
    localparam logic [4*N_DIG-1:0] ONE = (4*N_DIG)'(1);

    logic [4*N_DIG-1:0] digits_q;
    logic [4*N_DIG-1:0] digits_inc;
    logic               carry;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digits_q <= ONE;
        end else if (inc) begin
            digits_q <= digits_inc;
        end
    end

    // Ripple carry: each 9 rolls to 0 and pushes the increment one digit up.
    always_comb begin
        digits_inc = digits_q;
        carry      = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        ndig = NDW'(1);
        for (int i = 1; i < N_DIG; i++) begin
            if (digits_q[4*i +: 4] != 4'd0) begin
                ndig = NDW'(i + 1);
            end
        end
    end

    assign digits = digits_q;
endmodule

// File: rtl/fizzbuzz_gen.sv
// FizzBuzz line generator for 1..MAX_N, paced one byte at a time by tx_busy.
module fizzbuzz_gen
    import fizzbuzz_pkg::*;
#(
    parameter int MAX_N = 100,
    parameter int N_DIG = 4
) (
    input  logic           clk,
    input  logic           rst,
    fizzbuzz_gen_if.master bus,
    output state_t         dbg_state
);
    localparam int NDW = $clog2(N_DIG + 1);
    localparam logic [13:0] LAST_N = 14'(MAX_N);

    state_t             state;
    state_t             state_nx;
    logic [13:0]        n;
    logic [1:0]         mod3;
    logic [2:0]         mod5;
    line_t              kind;
    logic [3:0]         idx;
    logic [3:0]         cnt;
    logic               first_wait;
    logic [4*N_DIG-1:0] digits;
    logic [NDW-1:0]     ndig;
    logic [3:0]         pos;
    logic [3:0]         digit;
    logic [7:0]         cur_char;
    logic               start_ok;
    logic               last_char;
    logic               at_last_n;

    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // A start coinciding with the done pulse belongs to the finished run.
    assign start_ok  = (state == ST_IDLE) && bus.start && !done_q;
    assign last_char = (idx == cnt - 4'd1);
    assign at_last_n = (n == LAST_N);

    bcd_counter #(.N_DIG(N_DIG)) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == ST_DONE),
        .inc    ((state == ST_NEXT) && !at_last_n),
        .digits (digits),
        .ndig   (ndig)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_ok) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: if (!bus.tx_busy) state_nx = ST_WAIT;
            ST_WAIT: if (!first_wait && !bus.tx_busy) state_nx = last_char ? ST_NEXT : ST_SEND;
            ST_NEXT: state_nx = at_last_n ? ST_DONE : ST_LOAD;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_d = (state == ST_SEND) && !bus.tx_busy;
        tx_data_d  = tx_valid_d ? cur_char : tx_data_q;
        done_d     = (state == ST_DONE);
        busy_d     = busy_q;
        if (start_ok) busy_d = 1'b1;
        if (state == ST_DONE) busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Numbers are emitted MSB first, so the digit index counts down from ndig-1.
    always_comb begin
        pos      = 4'(ndig) - 4'd1 - idx;
        digit    = 4'(digits >> {pos, 2'b00});
        cur_char = CH_CR;
        if (last_char) begin
            cur_char = CH_LF;
        end else if (idx == cnt - 4'd2) begin
            cur_char = CH_CR;
        end else begin
            case (kind)
                LT_FIZZ:     cur_char = FIZZ[idx[1:0]];
                LT_BUZZ:     cur_char = BUZZ[idx[1:0]];
                LT_FIZZBUZZ: cur_char = idx[2] ? BUZZ[idx[1:0]] : FIZZ[idx[1:0]];
                default:     cur_char = CH_ZERO + {4'd0, digit};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n          <= 14'd1;
            mod3       <= 2'd1;
            mod5       <= 3'd1;
            kind       <= LT_NUM;
            idx        <= 4'd0;
            cnt        <= 4'd0;
            first_wait <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    idx <= 4'd0;
                    if (mod3 == 2'd0 && mod5 == 3'd0) begin
                        kind <= LT_FIZZBUZZ;
                        cnt  <= 4'd10;
                    end else if (mod3 == 2'd0) begin
                        kind <= LT_FIZZ;
                        cnt  <= 4'd6;
                    end else if (mod5 == 3'd0) begin
                        kind <= LT_BUZZ;
                        cnt  <= 4'd6;
                    end else begin
                        kind <= LT_NUM;
                        cnt  <= 4'(ndig) + 4'd2;
                    end
                end
                ST_SEND: begin
                    if (!bus.tx_busy) first_wait <= 1'b1;
                end
                ST_WAIT: begin
                    first_wait <= 1'b0;
                    if (!first_wait && !bus.tx_busy) idx <= idx + 4'd1;
                end
                ST_NEXT: begin
                    if (!at_last_n) begin
                        n    <= n + 14'd1;
                        mod3 <= (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
                        mod5 <= (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
                    end
                end
                ST_DONE: begin
                    n    <= 14'd1;
                    mod3 <= 2'd1;
                    mod5 <= 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_fizzbuzz_gen.sv
// Scoreboard bench: three generators (MAX_N 15, 100, 1) with byte-sink models.
module tb_fizzbuzz_gen;
    import fizzbuzz_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fizzbuzz_gen_if bus15 ();
    fizzbuzz_gen_if bus100 ();
    fizzbuzz_gen_if bus1 ();
    state_t st15, st100, st1;

    fizzbuzz_gen #(.MAX_N(15))  u15  (.clk(clk), .rst(rst), .bus(bus15),  .dbg_state(st15));
    fizzbuzz_gen #(.MAX_N(100)) u100 (.clk(clk), .rst(rst), .bus(bus100), .dbg_state(st100));
    fizzbuzz_gen #(.MAX_N(1))   u1   (.clk(clk), .rst(rst), .bus(bus1),   .dbg_state(st1));

    logic [7:0] exp15[$], exp100[$], exp1[$];
    int n_checks = 0, n_pass = 0;
    int bytes15 = 0, bytes100 = 0, bytes1 = 0;
    int done15 = 0, done100 = 0, done1 = 0;
    int hold15 = 0, hold100 = 0, vwb15 = 0;
    bit stall15 = 1'b0;
    int lat, tot100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic void push_byte(input int w, input logic [7:0] b);
        case (w)
            0:       exp15.push_back(b);
            1:       exp100.push_back(b);
            default: exp1.push_back(b);
        endcase
    endfunction

    function automatic void push_line(input int w, input int n);
        string s;
        if (n % 15 == 0)     s = "FizzBuzz";
        else if (n % 3 == 0) s = "Fizz";
        else if (n % 5 == 0) s = "Buzz";
        else                 s = $sformatf("%0d", n);
        for (int i = 0; i < s.len(); i++) push_byte(w, s[i]);
        push_byte(w, 8'h0D);
        push_byte(w, 8'h0A);
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return bus15.done;
            1:       return bus100.done;
            default: return bus1.done;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       bus15.start = v;
            1:       bus100.start = v;
            default: bus1.start = v;
        endcase
    endtask

    task automatic pulse_start(input int w);
        set_start(w, 1'b1);
        @(negedge clk); #1;
        set_start(w, 1'b0);
    endtask

    task automatic wait_done(input int w, input int budget);
        int c = 0;
        while (!done_of(w) && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        chk($sformatf("u%0d_done_within_budget", w), done_of(w), 1);
    endtask

    task automatic wait_bytes15(input int n, input int budget);
        int c = 0;
        while (bytes15 < n && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        chk($sformatf("u15_reach_%0d_bytes", n), bytes15 >= n, 1);
    endtask

    // Sink/monitor for MAX_N=15: busy 3 cycles per byte, 50 when a stall is armed.
    initial begin
        bus15.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold15 = 0;
            end else begin
                if (hold15 > 0) hold15--;
                if (bus15.tx_valid) begin
                    if (bus15.tx_busy) vwb15++;
                    chk("u15_byte_expected", exp15.size() > 0, 1);
                    if (exp15.size() > 0) chk($sformatf("u15_byte%0d", bytes15), bus15.tx_data, exp15.pop_front());
                    bytes15++;
                    hold15 = stall15 ? 50 : 3;
                    stall15 = 1'b0;
                end
                if (bus15.done) begin
                    done15++;
                    chk("u15_queue_empty_at_done", exp15.size(), 0);
                end
            end
            bus15.tx_busy = (hold15 > 0);
        end
    end

    initial begin
        bus100.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold100 = 0;
            end else begin
                if (hold100 > 0) hold100--;
                if (bus100.tx_valid) begin
                    chk("u100_byte_expected", exp100.size() > 0, 1);
                    if (exp100.size() > 0) chk($sformatf("u100_byte%0d", bytes100), bus100.tx_data, exp100.pop_front());
                    bytes100++;
                    hold100 = 1;
                end
                if (bus100.done) begin
                    done100++;
                    chk("u100_queue_empty_at_done", exp100.size(), 0);
                end
            end
            bus100.tx_busy = (hold100 > 0);
        end
    end

    // MAX_N=1 sink is never busy.
    initial begin
        bus1.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus1.tx_valid) begin
                    chk("u1_busy_during_run", bus1.busy, 1);
                    chk("u1_byte_expected", exp1.size() > 0, 1);
                    if (exp1.size() > 0) chk($sformatf("u1_byte%0d", bytes1), bus1.tx_data, exp1.pop_front());
                    bytes1++;
                end
                if (bus1.done) begin
                    done1++;
                    chk("u1_queue_empty_at_done", exp1.size(), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus15.start = 1'b0;
        bus100.start = 1'b0;
        bus1.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_valid", bus15.tx_valid, 0);
        chk("rst_tx_data", bus15.tx_data, 0);
        chk("rst_busy", bus15.busy, 0);
        chk("rst_done", bus15.done, 0);
        chk("rst_state", st15, ST_IDLE);
        chk("rst_u100_valid", bus100.tx_valid, 0);
        chk("rst_u1_busy", bus1.busy, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Run 1: latency, ignored mid-run start, long stall.
        for (int n = 1; n <= 15; n++) push_line(0, n);
        bus15.start = 1'b1;
        @(negedge clk); #1;
        bus15.start = 1'b0;
        lat = 1;
        chk("u15_busy_after_start", bus15.busy, 1);
        while (!bus15.tx_valid && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        chk("u15_first_byte_latency", lat, 3);
        wait_bytes15(20, 2000);
        pulse_start(0);
        wait_bytes15(30, 2000);
        stall15 = 1'b1;
        wait_done(0, 5000);
        // Start in the same cycle as done must be ignored.
        bus15.start = 1'b1;
        @(negedge clk); #1;
        bus15.start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("u15_start_at_done_busy", bus15.busy, 0);
        chk("u15_start_at_done_state", st15, ST_IDLE);
        chk("u15_run1_bytes", bytes15, 73);
        chk("u15_run1_done_count", done15, 1);
        chk("u15_no_valid_while_busy", vwb15, 0);

        // Run 2: reset after "Fi" of line 3.
        bytes15 = 0;
        for (int n = 1; n <= 15; n++) push_line(0, n);
        pulse_start(0);
        wait_bytes15(8, 2000);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("u15_rst_mid_valid", bus15.tx_valid, 0);
        chk("u15_rst_mid_busy", bus15.busy, 0);
        chk("u15_rst_mid_state", st15, ST_IDLE);
        rst = 1'b0;
        exp15.delete();
        bytes15 = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("u15_rst_no_done", done15, 1);

        // Run 3: restart after reset, full stream again.
        for (int n = 1; n <= 15; n++) push_line(0, n);
        pulse_start(0);
        wait_done(0, 5000);
        @(negedge clk); #1;
        chk("u15_run3_bytes", bytes15, 73);
        chk("u15_run3_done_count", done15, 2);

        // MAX_N=1: exactly "1\r\n".
        push_line(2, 1);
        pulse_start(2);
        wait_done(2, 500);
        chk("u1_busy_clear_at_done", bus1.busy, 0);
        @(negedge clk); #1;
        chk("u1_bytes", bytes1, 3);
        chk("u1_done_count", done1, 1);

        // MAX_N=100: exercises BCD carries 9->10 and 99->100.
        for (int n = 1; n <= 100; n++) push_line(1, n);
        tot100 = exp100.size();
        pulse_start(1);
        wait_done(1, 20000);
        @(negedge clk); #1;
        chk("u100_bytes", bytes100, tot100);
        chk("u100_done_count", done100, 1);
        chk("u100_state_idle", st100, ST_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
